// File: rtl/fp_add_pkg.sv
// Shared FSM state type and width/field helpers for the sequential FP adder.
// Helpers are width-generic so any EXP_W/MAN_W split (word up to 64 bits) can use them.
package fp_add_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_ADD   = 3'd2,
    ST_NORM  = 3'd3,
    ST_ROUND = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam int GRS_W = 3;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int fp_word_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  // {carry, hidden, frac, guard, round, sticky}
  function automatic int fp_mant_w(input int man_w);
    return man_w + 2 + GRS_W;
  endfunction

  function automatic logic [63:0] fp_exp_field(input logic [63:0] x, input int exp_w,
                                               input int man_w);
    return (x >> man_w) & ((64'd1 << exp_w) - 64'd1);
  endfunction

  function automatic logic [63:0] fp_frac_field(input logic [63:0] x, input int man_w);
    return x & ((64'd1 << man_w) - 64'd1);
  endfunction

endpackage

// File: rtl/fp_align_shifter.sv
// Right shifter for operand alignment; sticky_o is the OR of every bit pushed
// past the LSB, so shifts wider than the word leave only sticky information.
module fp_align_shifter #(
  parameter int DATA_W  = 10,
  parameter int SHAMT_W = 4
) (
  input  logic [DATA_W-1:0]  data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic [DATA_W-1:0]  data_o,
  output logic               sticky_o
);

  always_comb begin
    data_o   = data_i >> shamt_i;
    sticky_o = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < int'(shamt_i)) sticky_o = sticky_o | data_i[i];
    end
  end

endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle add/sub for a float format without denormals, inf or NaN; one
// operation in flight, result held in DONE until the consumer takes it.
module fp_add_seq
  import fp_add_pkg::*;
#(
  parameter int EXP_W = 4,
  parameter int MAN_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   s,
  output logic                   ovf,
  output logic                   unf
);

  localparam int W  = fp_word_w(EXP_W, MAN_W);
  localparam int MW = fp_mant_w(MAN_W);
  localparam int EW = EXP_W + 1;  // spare bit exposes overflow before saturation

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic          sgn_q, sgn_d, sub_q, sub_d;
  logic [EW-1:0] exp_q, exp_d;
  logic [MW-1:0] mx_q, mx_d, mn_q, mn_d;
  logic [W-1:0]  res_q, res_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;

  function automatic logic [MW-1:0] unpack_mant(input logic [EXP_W-1:0] e,
                                                input logic [MAN_W-1:0] f);
    return (e == '0) ? '0 : {2'b01, f, 3'b000};
  endfunction

  logic             a_sgn, b_sgn;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frc, b_frc;

  assign a_sgn = a_q[W-1];
  assign b_sgn = b_q[W-1];
  assign a_exp = EXP_W'(fp_exp_field(64'(a_q), EXP_W, MAN_W));
  assign b_exp = EXP_W'(fp_exp_field(64'(b_q), EXP_W, MAN_W));
  assign a_frc = MAN_W'(fp_frac_field(64'(a_q), MAN_W));
  assign b_frc = MAN_W'(fp_frac_field(64'(b_q), MAN_W));

  logic             a_ge_b, big_sgn, sml_stk;
  logic [EXP_W-1:0] big_exp, sml_exp, exp_diff;
  logic [MW-1:0]    big_mant, sml_mant, sml_shf, sml_aln;

  assign a_ge_b   = {a_exp, a_frc} >= {b_exp, b_frc};
  assign big_sgn  = a_ge_b ? a_sgn : b_sgn;
  assign big_exp  = a_ge_b ? a_exp : b_exp;
  assign sml_exp  = a_ge_b ? b_exp : a_exp;
  assign big_mant = a_ge_b ? unpack_mant(a_exp, a_frc) : unpack_mant(b_exp, b_frc);
  assign sml_mant = a_ge_b ? unpack_mant(b_exp, b_frc) : unpack_mant(a_exp, a_frc);
  assign exp_diff = big_exp - sml_exp;

  fp_align_shifter #(
    .DATA_W  (MW),
    .SHAMT_W (EXP_W)
  ) u_align (
    .data_i   (sml_mant),
    .shamt_i  (exp_diff),
    .data_o   (sml_shf),
    .sticky_o (sml_stk)
  );

  assign sml_aln = {sml_shf[MW-1:1], sml_shf[0] | sml_stk};

  // Round-to-nearest-even on {hidden, frac} using guard/round/sticky
  logic             rnd_up, rnd_ovf;
  logic [MAN_W+1:0] rnd_sum;
  logic [EW-1:0]    rnd_exp;
  logic [MAN_W-1:0] rnd_frc;

  assign rnd_up  = mx_q[2] & (mx_q[3] | mx_q[1] | mx_q[0]);
  assign rnd_sum = {1'b0, mx_q[MW-2:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
  assign rnd_exp = exp_q + {{(EW-1){1'b0}}, rnd_sum[MAN_W+1]};
  assign rnd_frc = rnd_sum[MAN_W+1] ? rnd_sum[MAN_W:1] : rnd_sum[MAN_W-1:0];
  assign rnd_ovf = rnd_exp[EXP_W];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    sub_d   = sub_q;
    exp_d   = exp_q;
    mx_d    = mx_q;
    mn_d    = mn_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = {b[W-1] ^ op, b[W-2:0]};
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        sgn_d   = big_sgn;
        sub_d   = a_sgn ^ b_sgn;
        exp_d   = {1'b0, big_exp};
        mx_d    = big_mant;
        mn_d    = sml_aln;
        state_d = ST_ADD;
      end
      ST_ADD: begin
        mx_d    = sub_q ? (mx_q - mn_q) : (mx_q + mn_q);
        state_d = ST_NORM;
      end
      ST_NORM: begin
        if (mx_q == '0) begin
          res_d   = '0;
          state_d = ST_DONE;
        end else if (mx_q[MW-1]) begin
          mx_d    = {1'b0, mx_q[MW-1:2], mx_q[1] | mx_q[0]};
          exp_d   = exp_q + EW'(1);
          state_d = ST_ROUND;
        end else if (mx_q[MW-2]) begin
          state_d = ST_ROUND;
        end else if (exp_q == EW'(1)) begin
          res_d   = '0;
          unf_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          mx_d    = {mx_q[MW-2:0], 1'b0};
          exp_d   = exp_q - EW'(1);
        end
      end
      ST_ROUND: begin
        res_d   = rnd_ovf ? {sgn_q, {(W-1){1'b1}}}
                          : {sgn_q, rnd_exp[EXP_W-1:0], rnd_frc};
        ovf_d   = rnd_ovf;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      sub_q   <= 1'b0;
      exp_q   <= '0;
      mx_q    <= '0;
      mn_q    <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      sub_q   <= sub_d;
      exp_q   <= exp_d;
      mx_q    <= mx_d;
      mn_q    <= mn_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign s         = res_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

endmodule

// File: tb/tb_fp_add_seq.sv
// Bench for fp_add_seq (EXP_W=4, MAN_W=5): exact-arithmetic reference model,
// directed vectors with literal expectations, then randomized operations.
module tb_fp_add_seq;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, op, out_valid, out_ready, ovf, unf;
  logic [9:0] a, b, s;

  always #5 clk = ~clk;

  fp_add_seq #(.EXP_W(4), .MAN_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .ovf       (ovf),
    .unf       (unf)
  );

  typedef struct {
    logic [9:0] s;
    logic       ovf;
    logic       unf;
    int         lat;
  } res_t;

  int         n_vec = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         acc_cyc = 0;
  res_t       exp_r;
  logic       exp_act = 1'b0;
  logic       ov_prev = 1'b0;
  logic [9:0] got_s;
  logic       got_ovf, got_unf;
  int         got_lat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Values scaled so exponent 1 has weight 1; sum exactly, then round to 6 bits.
  function automatic res_t model(input logic [9:0] ta, input logic [9:0] tb, input logic top);
    res_t   r;
    int     ea, eb, emax, p, e, k;
    longint va, vb, v, mag, mant, rem, half;
    logic   sg;
    ea = int'(ta[8:5]);
    eb = int'(tb[8:5]);
    va = (ea == 0) ? 0 : longint'(32 + int'(ta[4:0])) << (ea - 1);
    vb = (eb == 0) ? 0 : longint'(32 + int'(tb[4:0])) << (eb - 1);
    if (ta[9]) va = -va;
    if (tb[9] ^ top) vb = -vb;
    v = va + vb;
    emax = (ea > eb) ? ea : eb;
    r.s = '0; r.ovf = 1'b0; r.unf = 1'b0; r.lat = 3;
    if (v == 0) return r;
    sg  = (v < 0);
    mag = sg ? -v : v;
    p = 0;
    for (int i = 0; i < 40; i++) if (mag[i]) p = i;
    e = p - 4;
    if (e < 1) begin
      r.unf = 1'b1;
      r.lat = 2 + emax;
      return r;
    end
    r.lat = 4 + ((emax > e) ? emax - e : 0);
    k    = p - 5;
    mant = mag >> k;
    rem  = mag - (mant << k);
    if (k > 0) begin
      half = longint'(1) << (k - 1);
      if (rem > half || (rem == half && mant[0])) mant++;
    end
    if (mant == 64) begin
      mant = 32;
      e++;
    end
    if (e > 15) begin
      r.s   = {sg, 9'h1FF};
      r.ovf = 1'b1;
    end else begin
      r.s = {sg, 4'(e), 5'(mant)};
    end
    return r;
  endfunction

  // Compare process: every cycle an operation is in flight or presenting a result.
  always @(negedge clk) begin
    if (rst_n && exp_act) begin
      if (out_valid) begin
        if (!ov_prev) begin
          got_s   = s;
          got_ovf = ovf;
          got_unf = unf;
          got_lat = cyc - acc_cyc;
          chk("latency", cyc - acc_cyc, exp_r.lat);
        end
        chk("s", s, exp_r.s);
        chk("ovf", ovf, exp_r.ovf);
        chk("unf", unf, exp_r.unf);
        chk("in_ready_done", in_ready, 0);
      end else begin
        chk("in_ready_busy", in_ready, 0);
      end
    end
    ov_prev = out_valid;
  end

  task automatic do_op(input logic [9:0] ta, input logic [9:0] tb, input logic top,
                       input int hold);
    int w;
    exp_r = model(ta, tb, top);
    @(negedge clk);
    a = ta; b = tb; op = top; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    exp_act  = 1'b1;
    in_valid = 1'b0;
    a = 10'($urandom); b = 10'($urandom); op = 1'($urandom);
    w = 0;
    while (!out_valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!out_valid) begin
      chk("out_valid_timeout", out_valid, 1);
      exp_act = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    exp_act   = 1'b0;
    @(negedge clk);
    chk("bubble_in_ready", in_ready, 1);
    chk("bubble_out_valid", out_valid, 0);
  endtask

  task automatic tp(input string nm, input logic [9:0] ta, input logic [9:0] tb,
                    input logic top, input int hold, input logic [9:0] es,
                    input logic eo, input logic eu, input int el);
    res_t m;
    m = model(ta, tb, top);
    chk({nm, "_model_s"}, m.s, es);
    chk({nm, "_model_lat"}, m.lat, el);
    do_op(ta, tb, top, hold);
    chk({nm, "_s"}, got_s, es);
    chk({nm, "_ovf"}, got_ovf, eo);
    chk({nm, "_unf"}, got_unf, eu);
    chk({nm, "_lat"}, got_lat, el);
  endtask

  logic [9:0] ra, rb;
  int         mode;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_s", s, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_unf", unf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    tp("add_basic",  10'h0E0, 10'h0E0, 1'b0, 0, 10'h100, 1'b0, 1'b0, 4);
    tp("exact_canc", 10'h0E0, 10'h0E0, 1'b1, 0, 10'h000, 1'b0, 1'b0, 3);
    tp("mass_canc",  10'h0E1, 10'h0E0, 1'b1, 0, 10'h040, 1'b0, 1'b0, 9);
    tp("tie_even",   10'h0E0, 10'h020, 1'b0, 0, 10'h0E0, 1'b0, 1'b0, 4);
    tp("tie_odd",    10'h0E1, 10'h020, 1'b0, 0, 10'h0E2, 1'b0, 1'b0, 4);
    tp("unf_now",    10'h021, 10'h020, 1'b1, 0, 10'h000, 1'b0, 1'b1, 3);
    tp("unf_late",   10'h061, 10'h060, 1'b1, 0, 10'h000, 1'b0, 1'b1, 5);
    tp("overflow",   10'h1FF, 10'h1FF, 1'b0, 0, 10'h1FF, 1'b1, 1'b0, 4);
    tp("ovf_clear",  10'h0E0, 10'h000, 1'b0, 5, 10'h0E0, 1'b0, 1'b0, 4);

    // Reset while the long cancellation is normalising
    @(negedge clk);
    a = 10'h0E1; b = 10'h0E0; op = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("norm_in_ready", in_ready, 0);
    chk("norm_out_valid", out_valid, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_s", s, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_unf", unf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tp("post_rst", 10'h0E0, 10'h0E0, 1'b0, 0, 10'h100, 1'b0, 1'b0, 4);

    for (int n = 0; n < 300; n++) begin
      ra = 10'($urandom);
      if ($urandom_range(0, 9) == 0) ra[8:5] = 4'd0;
      mode = int'($urandom_range(0, 3));
      case (mode)
        0: rb = 10'($urandom);
        1: rb = {1'($urandom), ra[8:5], ra[4:0] ^ 5'($urandom_range(0, 3))};
        2: begin
          rb = 10'($urandom);
          rb[8:5] = ra[8:5] + 4'($urandom_range(0, 2)) - 4'd1;
        end
        default: begin
          rb = ra;
          rb[9] = 1'($urandom);
        end
      endcase
      do_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
